// File: rtl/buffer_readout_pkg.sv
// Shared types for the buffer readout stage.
//   rd_state_e : readout FSM state encoding
//   idx_w()    : width of an index able to address n entries (min 1 bit)
package buffer_readout_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } rd_state_e;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/buffer_readout_if.sv
// Bundle of the accumulator-side and downstream-side signals of buffer_readout.
//   slave  : the readout block (consumes iEn/iData/iReady, drives the rest)
//   master : the surrounding environment (accumulator + downstream stage)
// Signals:
//   iEn    upstream bitstream advanced this cycle
//   iData  per-lane accumulated counts
//   oClear one-cycle clear to the accumulator
//   oStall upstream must hold the bitstream
//   oValid/iReady beat handshake; oData/oIdx/oSat beat payload
//   oDone  pulse after the last lane is accepted
interface buffer_readout_if
    import buffer_readout_pkg::*;
#(
    parameter int IDIM = 4,
    parameter int IWID = 32,
    parameter int OWID = 8
);
    localparam int IW = idx_w(IDIM);

    logic                       iEn;
    logic [IDIM-1:0][IWID-1:0]  iData;
    logic                       oClear;
    logic                       oStall;
    logic                       oValid;
    logic                       iReady;
    logic [OWID-1:0]            oData;
    logic [IW-1:0]              oIdx;
    logic                       oSat;
    logic                       oDone;

    modport slave (
        input  iEn, iData, iReady,
        output oClear, oStall, oValid, oData, oIdx, oSat, oDone
    );

    modport master (
        output iEn, iData, iReady,
        input  oClear, oStall, oValid, oData, oIdx, oSat, oDone
    );

endinterface

// File: rtl/buffer_readout_sat_shift.sv
// Combinational logical right shift followed by unsigned saturation from
// IWID down to OWID bits.
//   data_i : IWID-bit unsigned count
//   data_o : OWID-bit result, all ones when the shifted value does not fit
//   sat_o  : high when saturation was applied
module buffer_readout_sat_shift #(
    parameter int IWID  = 32,
    parameter int OWID  = 8,
    parameter int SHIFT = 0
) (
    input  logic [IWID-1:0] data_i,
    output logic [OWID-1:0] data_o,
    output logic            sat_o
);

    logic [IWID-1:0] v;

    assign v = data_i >> SHIFT;

    if (OWID < IWID) begin : g_sat
        // Any set bit above the output width means the value does not fit.
        assign sat_o  = |v[IWID-1:OWID];
        assign data_o = sat_o ? {OWID{1'b1}} : v[OWID-1:0];
    end else begin : g_pass
        assign sat_o  = 1'b0;
        assign data_o = OWID'(v);
    end

endmodule

// File: rtl/buffer_readout.sv
// Window controller and drain stage behind the BufferArray accumulator.
// Counts WINLEN enabled cycles, clears the accumulator, snapshots its lanes
// and streams them out one lane per valid/ready beat while the next window
// accumulates.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : buffer_readout_if.slave (see interface for signal list)
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_EMPTY   | no snapshot held; waiting for the window end event
// ST_CAPTURE | oClear cycle; iData holds the full window, latched at exit
// ST_DRAIN   | shadow lanes presented one per beat, idx_q selects the lane
module buffer_readout
    import buffer_readout_pkg::*;
#(
    parameter int IDIM   = 4,
    parameter int IWID   = 32,
    parameter int OWID   = 8,
    parameter int WINLEN = 256,
    parameter int SHIFT  = 0
) (
    input logic             clk,
    input logic             rst,
    buffer_readout_if.slave bus
);

    localparam int              IW       = idx_w(IDIM);
    localparam int              CW       = idx_w(WINLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WINLEN - 1);
    localparam logic [IW-1:0]   IDX_LAST = IW'(IDIM - 1);

    rd_state_e                  state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic [IDIM-1:0][IWID-1:0]  shadow_q, shadow_d;
    logic                       clear_q, clear_d;
    logic                       done_q, done_d;

    logic                       cnt_last;
    logic                       stall;
    logic                       adv;
    logic                       win_end;
    logic                       drain;
    logic [OWID-1:0]            sat_data;
    logic                       sat_flag;

    // A completed window waits at CNT_LAST (stalling upstream) until the
    // previous snapshot has fully drained.
    always_comb begin
        cnt_last = (cnt_q == CNT_LAST);
        stall    = clear_q | (cnt_last & (state_q != ST_EMPTY));
        adv      = bus.iEn & ~stall;
        win_end  = adv & cnt_last & (state_q == ST_EMPTY);
        clear_d  = win_end;

        cnt_d = cnt_q;
        if (win_end) begin
            cnt_d = '0;
        end else if (adv) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        done_d   = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                if (win_end) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // The final window bit was added at the win_end edge, so the
                // accumulator output is complete during this cycle.
                shadow_d = bus.iData;
                idx_d    = '0;
                state_d  = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (bus.iReady) begin
                    if (idx_q == IDX_LAST) begin
                        done_d  = 1'b1;
                        state_d = ST_EMPTY;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            clear_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            clear_q  <= clear_d;
            done_q   <= done_d;
        end
    end

    buffer_readout_sat_shift #(
        .IWID  (IWID),
        .OWID  (OWID),
        .SHIFT (SHIFT)
    ) u_sat (
        .data_i (shadow_q[idx_q]),
        .data_o (sat_data),
        .sat_o  (sat_flag)
    );

    assign drain      = (state_q == ST_DRAIN);
    assign bus.oValid = drain;
    assign bus.oData  = drain ? sat_data : '0;
    assign bus.oSat   = drain & sat_flag;
    assign bus.oIdx   = idx_q;
    assign bus.oClear = clear_q;
    assign bus.oStall = stall;
    assign bus.oDone  = done_q;

endmodule

// File: tb/tb_buffer_readout.sv
// Directed bench for buffer_readout: two instances (SHIFT=0 and SHIFT=2)
// share one accumulator model; expected beats are queued when a window is
// set up and popped by a monitor on each accepted beat.
module tb_buffer_readout;
    import buffer_readout_pkg::*;

    localparam int IDIM   = 4;
    localparam int IWID   = 32;
    localparam int OWID   = 8;
    localparam int WINLEN = 8;
    localparam int OMAX   = (1 << OWID) - 1;

    typedef struct {
        int idx;
        int data;
        int sat;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;
    logic rdy = 1'b0;
    logic use_pre = 1'b0;
    logic [IDIM-1:0][IWID-1:0] acc_q;
    logic [IDIM-1:0][IWID-1:0] pre;

    int    total = 0;
    int    bad   = 0;
    beat_t q0[$];
    beat_t q2[$];
    beat_t e0, e2;
    logic  pend0 = 1'b0;
    logic  pend2 = 1'b0;

    always #5 clk = ~clk;

    buffer_readout_if #(.IDIM(IDIM), .IWID(IWID), .OWID(OWID)) b0 ();
    buffer_readout_if #(.IDIM(IDIM), .IWID(IWID), .OWID(OWID)) b2 ();

    assign b0.iEn    = en;
    assign b2.iEn    = en;
    assign b0.iReady = rdy;
    assign b2.iReady = rdy;
    assign b0.iData  = use_pre ? pre : acc_q;
    assign b2.iData  = use_pre ? pre : acc_q;

    buffer_readout #(.IDIM(IDIM), .IWID(IWID), .OWID(OWID), .WINLEN(WINLEN), .SHIFT(0))
        dut0 (.clk(clk), .rst(rst), .bus(b0));
    buffer_readout #(.IDIM(IDIM), .IWID(IWID), .OWID(OWID), .WINLEN(WINLEN), .SHIFT(2))
        dut2 (.clk(clk), .rst(rst), .bus(b2));

    // BufferArray stand-in: every lane sees a 1 on each advanced cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (b0.oClear) begin
            acc_q <= '0;
        end else if (en && !b0.oStall) begin
            for (int i = 0; i < IDIM; i++) acc_q[i] <= acc_q[i] + 32'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int ref_data(input longint v, input int sh);
        longint s;
        s = v >> sh;
        return (s > OMAX) ? OMAX : int'(s);
    endfunction

    function automatic int ref_sat(input longint v, input int sh);
        return ((v >> sh) > OMAX) ? 1 : 0;
    endfunction

    task automatic push_uniform(input int v);
        for (int i = 0; i < IDIM; i++) begin
            q0.push_back('{idx: i, data: ref_data(v, 0), sat: ref_sat(v, 0)});
            q2.push_back('{idx: i, data: ref_data(v, 2), sat: ref_sat(v, 2)});
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            pend0 = 1'b0;
            pend2 = 1'b0;
        end else begin
            chk("done0", b0.oDone, pend0);
            chk("done2", b2.oDone, pend2);
            pend0 = 1'b0;
            pend2 = 1'b0;
            if (b0.oValid && b0.iReady) begin
                total++;
                assert (q0.size() != 0) else begin
                    bad++;
                    $error("FAIL extra_beat0 got=idx%0d exp=none", b0.oIdx);
                end
                if (q0.size() != 0) begin
                    e0 = q0.pop_front();
                    chk("idx0", b0.oIdx, e0.idx);
                    chk("data0", b0.oData, e0.data);
                    chk("sat0", b0.oSat, e0.sat);
                    pend0 = (e0.idx == IDIM - 1);
                end
            end
            if (b2.oValid && b2.iReady) begin
                total++;
                assert (q2.size() != 0) else begin
                    bad++;
                    $error("FAIL extra_beat2 got=idx%0d exp=none", b2.oIdx);
                end
                if (q2.size() != 0) begin
                    e2 = q2.pop_front();
                    chk("idx2", b2.oIdx, e2.idx);
                    chk("data2", b2.oData, e2.data);
                    chk("sat2", b2.oSat, e2.sat);
                    pend2 = (e2.idx == IDIM - 1);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        en  = 1'b0;
        rdy = 1'b0;
        q0.delete();
        q2.delete();
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic wait_beat(input int idx, input int budget);
        int n;
        n = 0;
        while (!(b0.oValid && b0.oIdx == 2'(idx)) && n < budget) begin
            step();
            n++;
        end
        chk("wait_beat", 32'(b0.oValid && b0.oIdx == 2'(idx)), 1);
    endtask

    task automatic wait_empty(input int budget);
        int n;
        n = 0;
        while ((q0.size() != 0 || q2.size() != 0) && n < budget) begin
            step();
            n++;
        end
        chk("drain_done", q0.size() + q2.size(), 0);
    endtask

    initial begin
        pre = '0;
        #2 rst = 1'b1;

        // Reset held with random inputs.
        for (int k = 0; k < 8; k++) begin
            en  = 1'($urandom_range(0, 1));
            rdy = 1'($urandom_range(0, 1));
            step();
            chk("rst_clear", b0.oClear, 0);
            chk("rst_stall", b0.oStall, 0);
            chk("rst_valid", b0.oValid, 0);
            chk("rst_done",  b0.oDone, 0);
            chk("rst_data",  b0.oData, 0);
            chk("rst_valid2", b2.oValid, 0);
        end

        // Basic window, all-ones input, ready held high.
        rst = 1'b0;
        en  = 1'b1;
        rdy = 1'b1;
        push_uniform(WINLEN);
        for (int c = 1; c <= 15; c++) begin
            chk("clear_cyc", b0.oClear, 32'(c == 9));
            chk("stall_cyc", b0.oStall, 32'(c == 9));
            chk("valid_cyc", b0.oValid, 32'(c >= 10 && c <= 13));
            chk("done_cyc",  b0.oDone,  32'(c == 14));
            if (c >= 10 && c <= 13) chk("idx_cyc", b0.oIdx, 32'(c - 10));
            if (c == 10) chk("acc_cleared", acc_q[0], 0);
            step();
        end
        en = 1'b0;
        wait_empty(20);

        // Backpressure on lane 1.
        do_reset(2);
        en  = 1'b1;
        rdy = 1'b1;
        push_uniform(WINLEN);
        wait_beat(1, 30);
        rdy = 1'b0;
        en  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", b0.oValid, 1);
            chk("bp_idx",   b0.oIdx, 1);
            chk("bp_data",  b0.oData, 8);
            chk("bp_data2", b2.oData, 2);
            step();
        end
        rdy = 1'b1;
        wait_empty(20);

        // Second window completes while the first is still held.
        do_reset(2);
        en  = 1'b1;
        rdy = 1'b1;
        push_uniform(WINLEN);
        wait_beat(0, 30);
        rdy = 1'b0;
        repeat (10) step();
        chk("ovl_stall", b0.oStall, 1);
        chk("ovl_valid", b0.oValid, 1);
        chk("ovl_idx",   b0.oIdx, 0);
        chk("ovl_acc",   acc_q[0], WINLEN - 1);
        repeat (3) step();
        chk("ovl_stall_hold", b0.oStall, 1);
        chk("ovl_acc_hold",   acc_q[0], WINLEN - 1);
        push_uniform(WINLEN);
        rdy = 1'b1;
        wait_empty(60);
        en = 1'b0;

        // Saturation with preloaded counts.
        do_reset(2);
        pre[0] = 32'd300;
        pre[1] = 32'd255;
        pre[2] = 32'd256;
        pre[3] = 32'd3;
        use_pre = 1'b1;
        q0.push_back('{idx: 0, data: 255, sat: 1});
        q0.push_back('{idx: 1, data: 255, sat: 0});
        q0.push_back('{idx: 2, data: 255, sat: 1});
        q0.push_back('{idx: 3, data: 3,   sat: 0});
        q2.push_back('{idx: 0, data: 75,  sat: 0});
        q2.push_back('{idx: 1, data: 63,  sat: 0});
        q2.push_back('{idx: 2, data: 64,  sat: 0});
        q2.push_back('{idx: 3, data: 0,   sat: 0});
        en  = 1'b1;
        rdy = 1'b1;
        wait_empty(40);
        en = 1'b0;
        use_pre = 1'b0;

        // Reset in the middle of a drain.
        do_reset(2);
        en  = 1'b1;
        rdy = 1'b1;
        push_uniform(WINLEN);
        wait_beat(1, 30);
        rst = 1'b1;
        #1;
        chk("mid_valid", b0.oValid, 0);
        chk("mid_stall", b0.oStall, 0);
        chk("mid_cnt",   dut0.cnt_q, 0);
        chk("mid_left",  q0.size(), 3);
        q0.delete();
        q2.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_uniform(WINLEN);
        for (int c = 1; c <= 9; c++) begin
            chk("post_clear", b0.oClear, 32'(c == 9));
            step();
        end
        wait_empty(20);
        en = 1'b0;
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/buffer_readout.md
Name: buffer_readout

Overview:
- Window controller and drain stage that sits directly downstream of the BufferArray accumulator.
- Counts a fixed accumulation window of enabled cycles, then pulses the accumulator's clear and snapshots its per-lane counts into shadow registers.
- Streams the snapshot out one lane per valid/ready beat, right-shifted and saturated to a narrower width, for the next uBrain stage.
- A new window accumulates while the previous snapshot drains.

Parameters:
- IDIM, 4, number of lanes (matches the accumulator's lane count).
- IWID, 32, width of each incoming accumulated count.
- OWID, 8, width of each emitted value.
- WINLEN, 256, enabled cycles per accumulation window; must be at least 2.
- SHIFT, 0, right shift applied to each count before saturation; must satisfy 0 ≤ SHIFT < IWID.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- iEn, in, 1, upstream bitstream advanced this cycle; counts toward the window.
- iData, in, [IWID-1:0] x IDIM, accumulated counts from the accumulator.
- oClear, out, 1, one-cycle clear to the accumulator.
- oStall, out, 1, upstream must hold (not advance) the bitstream this cycle.
- oValid, out, 1, oData/oIdx/oSat valid.
- iReady, in, 1, downstream accepts the beat.
- oData, out, OWID, shifted and saturated count.
- oIdx, out, clog2(IDIM), lane index of the current beat.
- oSat, out, 1, current beat was saturated.
- oDone, out, 1, one-cycle pulse on acceptance of the last lane.

Behaviour:
- Reset is asynchronous, active-high, and may hit any cycle, including mid-drain.
- Reset values: all outputs 0; window counter cnt = 0; shadow registers 0; readout FSM in EMPTY; any in-flight snapshot is discarded.
- Window counter:
  - cnt advances by 1 on cycles with iEn=1 and oStall=0.
  - Window end event E = iEn & !oStall & (cnt == WINLEN-1) & (FSM == EMPTY).
  - On E: cnt <= 0 and oClear <= 1 (registered), so oClear is high for exactly the next cycle.
- oStall (combinational) = oClear | ((cnt == WINLEN-1) & (FSM != EMPTY)).
  - When the window is complete but the previous drain is unfinished, cnt holds at WINLEN-1 and upstream is stalled.
  - E fires on the first enabled cycle after the FSM returns to EMPTY.
- Readout FSM states: EMPTY, CAPTURE, DRAIN.
  - EMPTY -> CAPTURE on E.
  - CAPTURE (the oClear-high cycle): at the closing edge, shadow[i] <= iData[i] for all lanes. iData then holds the full window because the last bit was accumulated at the E edge. Also idx <= 0. Go to DRAIN.
  - DRAIN: oValid = 1. oData, oIdx and oSat are combinational from shadow[idx] and idx, and stay stable while iReady=0.
    - On oValid & iReady with idx < IDIM-1: idx++.
    - On oValid & iReady with idx == IDIM-1: oDone pulses (registered, one cycle after the handshake); go to EMPTY.
- Arithmetic per lane:
  - v = shadow[idx] >> SHIFT (logical).
  - If v > 2^OWID-1: oData = all ones, oSat = 1. Otherwise oData = v[OWID-1:0], oSat = 0.
- Latency: the first beat is valid 2 cycles after the E edge (edge 1 enters CAPTURE, edge 2 enters DRAIN). With iReady held at 1, the drain takes exactly IDIM cycles.
- iEn=1 during an oStall cycle is ignored: cnt does not change and no window credit is given.
- E and the last handshake of a previous drain cannot coincide, because E requires FSM == EMPTY.

Decomposition:
- Shared package: FSM state enum (EMPTY, CAPTURE, DRAIN) and the lane-index width function.
- One natural sub-module: sat_shift (combinational shift-and-saturate, IWID->OWID with a sat flag), reused by later requant stages.

Test Plan:
- Reset: hold rst=1, drive random iEn/iReady -> oClear=oStall=oValid=oDone=0 and oData=0 throughout.
- Basic window (WINLEN=8, IDIM=4, SHIFT=0): bench BufferArray fed all-ones, iEn=1, iReady=1 -> oClear high exactly in cycle 9, oValid beats at cycles 10-13 with oIdx 0,1,2,3, oData=8 each, oDone pulse the cycle after beat 3. The accumulator reads 0 after the clear.
- Backpressure: iReady=0 for 5 cycles during DRAIN -> oValid stays 1 and oData/oIdx stay constant; no lane is skipped or duplicated.
- Overlap stall: iReady=0 through the whole second window -> cnt holds at 7 and oStall=1. After the drain completes, E fires, the next snapshot holds 8 per lane, and no input bit is lost.
- Saturation: preload counts 300/255/256/3 with SHIFT=0 -> oData 255/255/255/3, oSat 1/0/1/0. With SHIFT=2 -> 75/63/64/0, oSat all 0.
- Mid-drain reset: assert rst at beat oIdx=1 -> oValid drops immediately and cnt=0. After release, a fresh full window is needed before the next oClear.
